// File: rtl/tft_bus_arbiter_if.sv
// Requester-side handshake bundle for tft_bus_arbiter: command and pixel
// valid/ready channels, the frame_start pulse and the busy status.
interface tft_bus_arbiter_if;
  logic        cmd_valid;
  logic        cmd_rs;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        frame_start;
  logic        busy;

  modport master (
    output cmd_valid, cmd_rs, cmd_data, pix_valid, pix_data, frame_start,
    input  cmd_ready, pix_ready, busy
  );

  modport slave (
    input  cmd_valid, cmd_rs, cmd_data, pix_valid, pix_data, frame_start,
    output cmd_ready, pix_ready, busy
  );
endinterface

// File: rtl/tft_bus_arbiter.sv
// Purpose: shares the 8080-style ILI9341 write bus between cmd and pixel requesters, auto-inserting RAMWR per frame.
// Latency: word on the pins one cycle after accept; one word per 1+WR_LOW_CYCLES+WR_HIGH_CYCLES cycles.
// Backpressure: ready only in IDLE for the granted requester; TFT_ARB_ROUND_ROBIN_EN selects alternating cmd/pixel grant.
module tft_bus_arbiter #(
  parameter int unsigned WR_LOW_CYCLES  = 2,
  parameter int unsigned WR_HIGH_CYCLES = 1,
  parameter logic [15:0] RAMWR_CMD      = 16'h002C
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tft_bus_arbiter_if.slave        bus,
  output logic                    screenRD,
  output logic                    screenWR,
  output logic                    screenRS,
  output logic [15:0]             screenData
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  localparam logic [3:0] LO_LOAD = 4'(WR_LOW_CYCLES - 1);
  localparam logic [3:0] HI_LOAD = 4'(WR_HIGH_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic        rs_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        ramwr_pend_q;
  logic        ramwr_pend_d;

  logic        idle;
  logic        pix_ok;
  logic        cmd_sel;
  logic        ram_sel;
  logic        pix_sel;
  logic        any_sel;
  logic        word_rs;
  logic [15:0] word_dat;

`ifdef TFT_ARB_ROUND_ROBIN_EN
  // Set when the last cmd/pixel grant went to cmd; reset favours cmd first.
  logic        last_cmd_q;
`endif

  assign idle   = (state_q == IDLE);
  // A pending RAMWR hides the pixel requester so no pixel can overtake it.
  assign pix_ok = bus.pix_valid && !ramwr_pend_q;

`ifdef TFT_ARB_ROUND_ROBIN_EN
  assign cmd_sel = bus.cmd_valid && !(pix_ok && last_cmd_q);
`else
  assign cmd_sel = bus.cmd_valid;
`endif
  assign ram_sel = !cmd_sel && ramwr_pend_q;
  assign pix_sel = !cmd_sel && pix_ok;
  assign any_sel = idle && (cmd_sel || ram_sel || pix_sel);

  always_comb begin
    word_rs  = 1'b1;
    word_dat = bus.pix_data;
    if (cmd_sel) begin
      word_rs  = bus.cmd_rs;
      word_dat = bus.cmd_data;
    end else if (ram_sel) begin
      word_rs  = 1'b0;
      word_dat = RAMWR_CMD;
    end
  end

  // A frame_start coinciding with the RAMWR accept wins, queuing another RAMWR.
  assign ramwr_pend_d = bus.frame_start ? 1'b1
                      : ((idle && ram_sel) ? 1'b0 : ramwr_pend_q);

  assign bus.cmd_ready = idle && cmd_sel;
  assign bus.pix_ready = idle && pix_sel;
  assign bus.busy      = busy_q;

  assign screenRD   = 1'b1;
  assign screenWR   = wr_q;
  assign screenRS   = rs_q;
  assign screenData = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b1;
      rs_q         <= 1'b1;
      data_q       <= 16'h0000;
      busy_q       <= 1'b0;
      ramwr_pend_q <= 1'b0;
`ifdef TFT_ARB_ROUND_ROBIN_EN
      last_cmd_q   <= 1'b0;
`endif
    end else begin
      ramwr_pend_q <= ramwr_pend_d;
`ifdef TFT_ARB_ROUND_ROBIN_EN
      if (idle && cmd_sel) begin
        last_cmd_q <= 1'b1;
      end else if (idle && pix_sel) begin
        last_cmd_q <= 1'b0;
      end
`endif
      case (state_q)
        IDLE: begin
          if (any_sel) begin
            state_q <= WR_LO;
            busy_q  <= 1'b1;
            wr_q    <= 1'b0;
            cnt_q   <= LO_LOAD;
            rs_q    <= word_rs;
            data_q  <= word_dat;
          end
        end
        WR_LO: begin
          if (cnt_q == 4'd0) begin
            state_q <= WR_HI;
            wr_q    <= 1'b1;
            cnt_q   <= HI_LOAD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_HI: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wr_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Bench for tft_bus_arbiter: directed scenarios with literal expectations plus
// randomized cmd/pixel/frame traffic checked every cycle against a timeline model.
module tb_tft_bus_arbiter;
  localparam int LO = 2;
  localparam int HI = 1;
  localparam int P  = 1 + LO + HI;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        screenRD, screenWR, screenRS;
  logic [15:0] screenData;

  tft_bus_arbiter_if bus();

  tft_bus_arbiter #(
    .WR_LOW_CYCLES (LO),
    .WR_HIGH_CYCLES(HI),
    .RAMWR_CMD     (16'h002C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .screenRD  (screenRD),
    .screenWR  (screenWR),
    .screenRS  (screenRS),
    .screenData(screenData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: cycles elapsed since the last accept (P or more means idle).
  int          m_k = P;
  logic        m_rs = 1'b1;
  logic [15:0] m_data = 16'h0000;
  logic        m_pend = 1'b0;
  logic        m_last_cmd = 1'b0;
  logic [16:0] exp_q[$];
  logic [16:0] wlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic idle, pix_ok, cmd_win, ram_acc, pix_acc;
    if (rst_n) begin
      idle   = (m_k >= P);
      pix_ok = bus.pix_valid && !m_pend;
`ifdef TFT_ARB_ROUND_ROBIN_EN
      cmd_win = bus.cmd_valid && !(pix_ok && m_last_cmd);
`else
      cmd_win = bus.cmd_valid;
`endif
      ram_acc = idle && !cmd_win && m_pend;
      pix_acc = idle && !cmd_win && pix_ok;
      chk("m_wr",   screenWR, !(m_k >= 1 && m_k <= LO));
      chk("m_busy", bus.busy, !idle);
      chk("m_rs",   screenRS, m_rs);
      chk("m_data", screenData, m_data);
      chk("m_cmd_ready", bus.cmd_ready, idle && cmd_win);
      chk("m_pix_ready", bus.pix_ready, pix_acc);
      chk("m_rd",   screenRD, 1'b1);
      if (m_k < P) m_k++;
      if (idle && cmd_win) begin
        m_rs = bus.cmd_rs; m_data = bus.cmd_data; m_k = 1; m_last_cmd = 1'b1;
      end else if (ram_acc) begin
        m_rs = 1'b0; m_data = 16'h002C; m_k = 1;
      end else if (pix_acc) begin
        m_rs = 1'b1; m_data = bus.pix_data; m_k = 1; m_last_cmd = 1'b0;
      end
      if (m_k == 1) exp_q.push_back({m_rs, m_data});
      m_pend = bus.frame_start ? 1'b1 : (ram_acc ? 1'b0 : m_pend);
    end
  end

  // Panel view: every rising WR edge outside reset delivers the next accepted word.
  always @(posedge screenWR) begin
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        chk("panel_unexpected_write", {screenRS, screenData}, 17'h1FFFF);
      end else begin
        chk("panel_word", {screenRS, screenData}, exp_q.pop_front());
      end
      wlog.push_back({screenRS, screenData});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
    m_k = P; m_rs = 1'b1; m_data = 16'h0000; m_pend = 1'b0; m_last_cmd = 1'b0;
    exp_q.delete(); wlog.delete();
    #1;
    chk("reset_wr_async", screenWR, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic rs, input logic [15:0] d);
    logic fired = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_rs = rs; bus.cmd_data = d;
    for (int t = 0; t < 2000 && !fired; t++) begin
      @(negedge clk);
      fired = bus.cmd_ready;
    end
    if (!fired) chk("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] d);
    logic fired = 1'b0;
    bus.pix_valid = 1'b1; bus.pix_data = d;
    for (int t = 0; t < 2000 && !fired; t++) begin
      @(negedge clk);
      fired = bus.pix_ready;
    end
    if (!fired) chk("pix_timeout", 0, 1);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
  endtask

  initial begin
    int n_c, n_p, n_ram;
    logic [7:0] order;
    logic c, p;
    bus.cmd_valid = 1'b0; bus.cmd_rs = 1'b0; bus.cmd_data = 16'h0;
    bus.pix_valid = 1'b0; bus.pix_data = 16'h0; bus.frame_start = 1'b0;
    tick(2);
    apply_reset();

    // Idle after reset: pins parked for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_wr", screenWR, 1'b1);
      chk("idle_rs", screenRS, 1'b1);
      chk("idle_data", screenData, 16'h0000);
      chk("idle_busy", bus.busy, 1'b0);
    end
    @(posedge clk); #1;

    // Single command word timing.
    apply_reset();
    bus.cmd_valid = 1'b1; bus.cmd_rs = 1'b0; bus.cmd_data = 16'h0011;
    @(negedge clk); chk("single_ready_N", bus.cmd_ready, 1'b1);
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    @(negedge clk); chk("single_wr_N1", screenWR, 1'b0);
    chk("single_rsdata_N1", {screenRS, screenData}, 17'h00011);
    @(negedge clk); chk("single_wr_N2", screenWR, 1'b0);
    @(negedge clk); chk("single_wr_N3", screenWR, 1'b1);
    chk("single_busy_N3", bus.busy, 1'b1);
    @(negedge clk); chk("single_busy_N4", bus.busy, 1'b0);
    chk("single_rsdata_N4", {screenRS, screenData}, 17'h00011);
    @(posedge clk); #1;

    // frame_start then a waiting pixel: RAMWR goes first, once.
    apply_reset();
    pulse_frame();
    bus.pix_valid = 1'b1; bus.pix_data = 16'hF800;
    @(negedge clk); chk("frame_pix_held", bus.pix_ready, 1'b0);
    @(posedge clk); #1;
    send_pix(16'hF800);
    tick(12);
    chk("frame_nwords", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("frame_word0", wlog[0], 17'h0002C);
      chk("frame_word1", wlog[1], 17'h1F800);
    end

    // cmd and pixel both held valid for 8 words.
    apply_reset();
    bus.cmd_valid = 1'b1; bus.cmd_rs = 1'b0; bus.cmd_data = 16'h1000;
    bus.pix_valid = 1'b1; bus.pix_data = 16'hA000;
    n_c = 0; n_p = 0; order = 8'h00;
    for (int t = 0; t < 200 && (n_c + n_p) < 8; t++) begin
      @(negedge clk); c = bus.cmd_ready; p = bus.pix_ready;
      @(posedge clk); #1;
      if (c) begin n_c++; order = {order[6:0], 1'b1}; bus.cmd_data = bus.cmd_data + 16'd1; end
      if (p) begin n_p++; order = {order[6:0], 1'b0}; bus.pix_data = bus.pix_data + 16'd1; end
    end
    bus.cmd_valid = 1'b0; bus.pix_valid = 1'b0;
`ifdef TFT_ARB_ROUND_ROBIN_EN
    chk("both_cmd_count", n_c, 4);
    chk("both_pix_count", n_p, 4);
    chk("both_order", order, 8'hAA);
`else
    chk("both_cmd_count", n_c, 8);
    chk("both_pix_count", n_p, 0);
    chk("both_order", order, 8'hFF);
`endif
    tick(10);

    // Two frame_start pulses 3 cycles apart while busy.
    apply_reset();
    fork
      begin send_cmd(1'b0, 16'h0001); send_cmd(1'b1, 16'h0002); end
      begin tick(1); pulse_frame(); tick(2); pulse_frame(); end
    join
    tick(20);
    n_ram = 0;
    foreach (wlog[i]) if (wlog[i] == 17'h0002C) n_ram++;
    chk("dbl_frame_ramwr_count", n_ram, 1);
    chk("dbl_frame_nwords", wlog.size(), 3);
    if (wlog.size() == 3) chk("dbl_frame_last", wlog[2], 17'h0002C);

    // Reset in the first low cycle: word dropped, not replayed.
    apply_reset();
    send_cmd(1'b1, 16'h0077);
    chk("midrst_wr_low", screenWR, 1'b0);
    apply_reset();
    send_cmd(1'b1, 16'h0055);
    tick(10);
    chk("midrst_nwords", wlog.size(), 1);
    if (wlog.size() == 1) chk("midrst_word", wlog[0], 17'h10055);

    // Randomized traffic against the model.
    apply_reset();
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          tick($urandom_range(0, 6));
          send_cmd(1'($urandom_range(0, 1)), 16'($urandom));
        end
      end
      begin
        for (int i = 0; i < 250; i++) begin
          tick($urandom_range(0, 2));
          send_pix(16'($urandom));
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          tick($urandom_range(10, 80));
          pulse_frame();
        end
      end
    join
    tick(30);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
